// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the write-back/commit stage: exception codes,
// CSR access opcodes and bit positions inside the exception vector.
package wb_commit_stage_pkg;

   localparam int XLEN   = 32;
   localparam int RF_AW  = 5;
   localparam int CSR_NW = 14;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;
   localparam logic [5:0] ECODE_INE = 6'h0D;

   localparam logic [8:0] ESUBCODE_NONE = 9'h000;
   localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RD   = 2'b01,
      CSR_OP_WR   = 2'b10,
      CSR_OP_XCHG = 2'b11
   } csr_op_e;

   // ex_vec layout, MSB first: {int, adef, ine, sys, brk, ale}
   localparam int EX_ALE  = 0;
   localparam int EX_BRK  = 1;
   localparam int EX_SYS  = 2;
   localparam int EX_INE  = 3;
   localparam int EX_ADEF = 4;
   localparam int EX_INT  = 5;

endpackage

// File: rtl/wb_commit_stage_ex_prio_enc.sv
// Fixed-priority exception encoder: picks the highest-priority pending
// exception from the latched vector and reports its ecode/esubcode.
module ex_prio_enc
   import wb_commit_stage_pkg::*;
(
   input  logic [5:0] ex_vec,
   output logic [5:0] ecode,
   output logic [8:0] esubcode,
   output logic       any
);

   // Priority: int > adef > ine > sys > brk > ale
   always_comb begin
      ecode    = ECODE_INT;
      esubcode = ESUBCODE_NONE;
      any      = |ex_vec;
      if (ex_vec[EX_INT]) begin
         ecode = ECODE_INT;
      end else if (ex_vec[EX_ADEF]) begin
         ecode    = ECODE_ADE;
         esubcode = ESUBCODE_ADEF;
      end else if (ex_vec[EX_INE]) begin
         ecode = ECODE_INE;
      end else if (ex_vec[EX_SYS]) begin
         ecode = ECODE_SYS;
      end else if (ex_vec[EX_BRK]) begin
         ecode = ECODE_BRK;
      end else if (ex_vec[EX_ALE]) begin
         ecode = ECODE_ALE;
      end
   end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back stage: latches the retiring instruction from MEM, resolves its
// exception, drives the CSR and regfile ports, raises the pipeline flush and
// keeps retire/exception performance counters.
module wb_commit_stage
   import wb_commit_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ms_to_ws_valid,
   output logic              ws_allowin,
   input  logic [XLEN-1:0]   ms_pc,
   input  logic [XLEN-1:0]   ms_result,
   input  logic [XLEN-1:0]   ms_vaddr,
   input  logic              ms_rf_we,
   input  logic [RF_AW-1:0]  ms_rf_waddr,
   input  logic [1:0]        ms_csr_op,
   input  logic [CSR_NW-1:0] ms_csr_num,
   input  logic [XLEN-1:0]   ms_csr_wdata,
   input  logic [XLEN-1:0]   ms_csr_mask,
   input  logic              ms_ertn,
   input  logic [5:0]        ms_ex_vec,
   input  logic [XLEN-1:0]   csr_rvalue,
   output logic              csr_re,
   output logic              csr_we,
   output logic [CSR_NW-1:0] csr_num,
   output logic [XLEN-1:0]   csr_wmask,
   output logic [XLEN-1:0]   csr_wvalue,
   output logic              wb_ex,
   output logic [5:0]        wb_ecode,
   output logic [8:0]        wb_esubcode,
   output logic [XLEN-1:0]   wb_pc,
   output logic [XLEN-1:0]   wb_vaddr,
   output logic              ertn_flush,
   output logic              wb_flush,
   output logic              rf_we,
   output logic [RF_AW-1:0]  rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic [31:0]       perf_retire_cnt,
   output logic [15:0]       perf_ex_cnt
);

   logic              ws_ready_go;
   logic              ws_valid;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   result_q;
   logic [XLEN-1:0]   vaddr_q;
   logic              rf_we_q;
   logic [RF_AW-1:0]  rf_waddr_q;
   csr_op_e           csr_op_q;
   logic [CSR_NW-1:0] csr_num_q;
   logic [XLEN-1:0]   csr_wdata_q;
   logic [XLEN-1:0]   csr_mask_q;
   logic              ertn_q;
   logic [5:0]        ex_vec_q;
   logic [5:0]        enc_ecode;
   logic [8:0]        enc_esubcode;
   logic              enc_any;

   assign ws_ready_go = 1'b1;
   assign ws_allowin  = ~ws_valid | ws_ready_go;

   // Pipeline latch; a committing flush kills the younger instruction arriving from MEM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ws_valid    <= 1'b0;
         pc_q        <= '0;
         result_q    <= '0;
         vaddr_q     <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         csr_op_q    <= CSR_OP_NONE;
         csr_num_q   <= '0;
         csr_wdata_q <= '0;
         csr_mask_q  <= '0;
         ertn_q      <= 1'b0;
         ex_vec_q    <= '0;
      end else begin
         if (wb_flush) begin
            ws_valid <= 1'b0;
         end else if (ws_allowin && ms_to_ws_valid) begin
            ws_valid <= 1'b1;
         end else if (ws_ready_go) begin
            ws_valid <= 1'b0;
         end
         if (ws_allowin && ms_to_ws_valid) begin
            pc_q        <= ms_pc;
            result_q    <= ms_result;
            vaddr_q     <= ms_vaddr;
            rf_we_q     <= ms_rf_we;
            rf_waddr_q  <= ms_rf_waddr;
            csr_op_q    <= csr_op_e'(ms_csr_op);
            csr_num_q   <= ms_csr_num;
            csr_wdata_q <= ms_csr_wdata;
            csr_mask_q  <= ms_csr_mask;
            ertn_q      <= ms_ertn;
            ex_vec_q    <= ms_ex_vec;
         end
      end
   end

   ex_prio_enc u_ex_prio_enc (
      .ex_vec   (ex_vec_q),
      .ecode    (enc_ecode),
      .esubcode (enc_esubcode),
      .any      (enc_any)
   );

   assign wb_ex       = ws_valid & enc_any;
   assign wb_ecode    = wb_ex ? enc_ecode    : '0;
   assign wb_esubcode = wb_ex ? enc_esubcode : '0;
   assign wb_pc       = ws_valid ? pc_q    : '0;
   assign wb_vaddr    = ws_valid ? vaddr_q : '0;
   // An exception on the ertn itself takes precedence over the return
   assign ertn_flush  = ws_valid & ertn_q & ~enc_any;
   assign wb_flush    = wb_ex | ertn_flush;

   assign csr_re     = ws_valid & (csr_op_q != CSR_OP_NONE);
   assign csr_we     = ws_valid & csr_op_q[1] & ~wb_ex;
   assign csr_num    = ws_valid ? csr_num_q   : '0;
   assign csr_wvalue = ws_valid ? csr_wdata_q : '0;

   // Write mask: full word for csrwr, rj mask for csrxchg, nothing otherwise
   always_comb begin
      csr_wmask = '0;
      if (ws_valid) begin
         if (csr_op_q == CSR_OP_WR) begin
            csr_wmask = '1;
         end else if (csr_op_q == CSR_OP_XCHG) begin
            csr_wmask = csr_mask_q;
         end
      end
   end

   // CSR instructions return the old CSR value into rd
   assign rf_we    = ws_valid & rf_we_q & ~wb_ex;
   assign rf_waddr = ws_valid ? rf_waddr_q : '0;
   assign rf_wdata = !ws_valid                  ? '0         :
                     (csr_op_q != CSR_OP_NONE)  ? csr_rvalue : result_q;

   // Retire counter wraps, exception counter saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_retire_cnt <= '0;
         perf_ex_cnt     <= '0;
      end else begin
         if (ws_valid && !wb_ex) begin
            perf_retire_cnt <= perf_retire_cnt + 32'd1;
         end
         if (wb_ex && (perf_ex_cnt != 16'hFFFF)) begin
            perf_ex_cnt <= perf_ex_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for the write-back stage: a vector table for single
// instructions plus hand-written sequences for reset, flush and counters.
module tb_wb_commit_stage;

   logic        clk;
   logic        rst;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc, ms_result, ms_vaddr;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [1:0]  ms_csr_op;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_csr_wdata, ms_csr_mask;
   logic        ms_ertn;
   logic [5:0]  ms_ex_vec;
   logic [31:0] csr_rvalue;
   logic        csr_re, csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask, csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, wb_vaddr;
   logic        ertn_flush, wb_flush;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] perf_retire_cnt;
   logic [15:0] perf_ex_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_retire = 0;
   int exp_ex = 0;

   wb_commit_stage dut (
      .clk             (clk),
      .rst             (rst),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ws_allowin      (ws_allowin),
      .ms_pc           (ms_pc),
      .ms_result       (ms_result),
      .ms_vaddr        (ms_vaddr),
      .ms_rf_we        (ms_rf_we),
      .ms_rf_waddr     (ms_rf_waddr),
      .ms_csr_op       (ms_csr_op),
      .ms_csr_num      (ms_csr_num),
      .ms_csr_wdata    (ms_csr_wdata),
      .ms_csr_mask     (ms_csr_mask),
      .ms_ertn         (ms_ertn),
      .ms_ex_vec       (ms_ex_vec),
      .csr_rvalue      (csr_rvalue),
      .csr_re          (csr_re),
      .csr_we          (csr_we),
      .csr_num         (csr_num),
      .csr_wmask       (csr_wmask),
      .csr_wvalue      (csr_wvalue),
      .wb_ex           (wb_ex),
      .wb_ecode        (wb_ecode),
      .wb_esubcode     (wb_esubcode),
      .wb_pc           (wb_pc),
      .wb_vaddr        (wb_vaddr),
      .ertn_flush      (ertn_flush),
      .wb_flush        (wb_flush),
      .rf_we           (rf_we),
      .rf_waddr        (rf_waddr),
      .rf_wdata        (rf_wdata),
      .perf_retire_cnt (perf_retire_cnt),
      .perf_ex_cnt     (perf_ex_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] result;
      logic [31:0] vaddr;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [1:0]  op;
      logic [13:0] num;
      logic [31:0] wdata;
      logic [31:0] mask;
      logic [31:0] rvalue;
      logic        ertn;
      logic [5:0]  ex;
      logic        e_ex;
      logic [5:0]  e_ecode;
      logic        e_ertn;
      logic        e_rf_we;
      logic [31:0] e_rf_wdata;
      logic        e_re;
      logic        e_we;
      logic [31:0] e_wmask;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] result, input logic [31:0] vaddr,
                        input logic rf_we_i, input logic [4:0] waddr, input logic [1:0] op,
                        input logic [13:0] num, input logic [31:0] wdata, input logic [31:0] mask,
                        input logic [31:0] rvalue, input logic ertn, input logic [5:0] ex);
      ms_to_ws_valid = 1'b1;
      ms_pc          = pc;
      ms_result      = result;
      ms_vaddr       = vaddr;
      ms_rf_we       = rf_we_i;
      ms_rf_waddr    = waddr;
      ms_csr_op      = op;
      ms_csr_num     = num;
      ms_csr_wdata   = wdata;
      ms_csr_mask    = mask;
      csr_rvalue     = rvalue;
      ms_ertn        = ertn;
      ms_ex_vec      = ex;
   endtask

   task automatic drive_clean(input logic [31:0] pc, input logic [31:0] result);
      drive(pc, result, 32'h0, 1'b1, 5'd1, 2'b00, 14'h0, 32'h0, 32'h0, 32'h0, 1'b0, 6'b000000);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " wb_ex"},      {31'b0, wb_ex},      32'h0);
      check({tag, " wb_flush"},   {31'b0, wb_flush},   32'h0);
      check({tag, " ertn_flush"}, {31'b0, ertn_flush}, 32'h0);
      check({tag, " rf_we"},      {31'b0, rf_we},      32'h0);
      check({tag, " rf_waddr"},   {27'b0, rf_waddr},   32'h0);
      check({tag, " rf_wdata"},   rf_wdata,            32'h0);
      check({tag, " wb_pc"},      wb_pc,               32'h0);
      check({tag, " csr_re"},     {31'b0, csr_re},     32'h0);
      check({tag, " csr_num"},    {18'b0, csr_num},    32'h0);
   endtask

   initial begin
      //          pc            result        vaddr         rfwe wa     op     num      wdata         mask          rvalue        ertn  ex        e_ex ec     ertn rfwe rf_wdata      re    we    wmask
      vecs[0]  = '{32'h1c000000, 32'hDEADBEEF, 32'h00000000, 1'b1, 5'd4,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b000000, 1'b0, 6'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{32'h1c000100, 32'h11111111, 32'h00000000, 1'b1, 5'd5,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b010100, 1'b1, 6'h8, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{32'h1c000200, 32'h22222222, 32'h00000000, 1'b1, 5'd6,  2'b11, 14'h030, 32'hAAAA5555, 32'h0000FFFF, 32'h12345678, 1'b0, 6'b000000, 1'b0, 6'h0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h0000FFFF};
      vecs[3]  = '{32'h1c000204, 32'h00000000, 32'h00000000, 1'b1, 5'd7,  2'b10, 14'h006, 32'hCAFEF00D, 32'hFFFF0000, 32'h0BADC0DE, 1'b0, 6'b000000, 1'b0, 6'h0, 1'b0, 1'b1, 32'h0BADC0DE, 1'b1, 1'b1, 32'hFFFFFFFF};
      vecs[4]  = '{32'h1c000208, 32'h00000033, 32'h00000000, 1'b1, 5'd8,  2'b01, 14'h001, 32'h00000055, 32'h0,        32'h87654321, 1'b0, 6'b000000, 1'b0, 6'h0, 1'b0, 1'b1, 32'h87654321, 1'b1, 1'b0, 32'h0};
      vecs[5]  = '{32'h1c000300, 32'h00000000, 32'h00000000, 1'b0, 5'd0,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b1, 6'b100000, 1'b1, 6'h0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{32'h1c000304, 32'h00000000, 32'h00000000, 1'b0, 5'd0,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b1, 6'b000000, 1'b0, 6'h0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{32'h1c000400, 32'h00000044, 32'h00000000, 1'b1, 5'd9,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b001011, 1'b1, 6'hD, 1'b0, 1'b0, 32'h00000044, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{32'h1c000404, 32'h00000000, 32'h00000000, 1'b0, 5'd0,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b000110, 1'b1, 6'hB, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{32'h1c000408, 32'h00000000, 32'h00000000, 1'b0, 5'd0,  2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b000011, 1'b1, 6'hC, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{32'h1c00040c, 32'h0000ABCD, 32'h00001003, 1'b1, 5'd10, 2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b000001, 1'b1, 6'h9, 1'b0, 1'b0, 32'h0000ABCD, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{32'h1c000410, 32'h00000000, 32'h00000002, 1'b1, 5'd11, 2'b10, 14'h040, 32'h00000001, 32'h0,        32'h77777777, 1'b0, 6'b000001, 1'b1, 6'h9, 1'b0, 1'b0, 32'h77777777, 1'b1, 1'b0, 32'hFFFFFFFF};
      vecs[12] = '{32'h1c000500, 32'h00000000, 32'h1c000500, 1'b1, 5'd12, 2'b00, 14'h000, 32'h0,        32'h0,        32'h0,        1'b0, 6'b010000, 1'b1, 6'h8, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h0};

      rst = 1'b1;
      ms_to_ws_valid = 1'b0;
      ms_pc = '0; ms_result = '0; ms_vaddr = '0; ms_rf_we = 1'b0; ms_rf_waddr = '0;
      ms_csr_op = '0; ms_csr_num = '0; ms_csr_wdata = '0; ms_csr_mask = '0;
      ms_ertn = 1'b0; ms_ex_vec = '0; csr_rvalue = '0;

      repeat (2) @(negedge clk);
      check_all_zero("por");
      check("por allowin", {31'b0, ws_allowin}, 32'h1);
      rst = 1'b0;

      // Reset mid-stream with an instruction in WB
      @(negedge clk);
      drive_clean(32'h1c001000, 32'h00000AAA);
      @(negedge clk);
      drive_clean(32'h1c001004, 32'h00000BBB);
      @(negedge clk);
      check("pre-rst rf_we", {31'b0, rf_we}, 32'h1);
      check("pre-rst retire", perf_retire_cnt, 32'd1);
      ms_to_ws_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      check("midrst retire", perf_retire_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post-rst retire", perf_retire_cnt, 32'd0);
      check("post-rst ex_cnt", {16'b0, perf_ex_cnt}, 32'd0);
      check_all_zero("post-rst");

      // Exception kills the younger instruction arriving in the same cycle
      drive(32'h1c002000, 32'h0, 32'h0, 1'b1, 5'd3, 2'b00, 14'h0, 32'h0, 32'h0, 32'h0, 1'b0, 6'b000001);
      @(negedge clk);
      check("flush wb_ex", {31'b0, wb_ex}, 32'h1);
      check("flush wb_flush", {31'b0, wb_flush}, 32'h1);
      check("flush rf_we", {31'b0, rf_we}, 32'h0);
      drive_clean(32'h1c002004, 32'h00000CCC);
      @(negedge clk);
      check("younger wb_ex", {31'b0, wb_ex}, 32'h0);
      check("younger rf_we", {31'b0, rf_we}, 32'h0);
      check("younger wb_pc", wb_pc, 32'h0);
      check("younger ex_cnt", {16'b0, perf_ex_cnt}, 32'd1);
      ms_to_ws_valid = 1'b0;
      @(negedge clk);
      check("younger retire", perf_retire_cnt, 32'd0);
      exp_ex = 1;
      exp_retire = 0;

      // Table of single instructions, each followed by an idle cycle
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].pc, vecs[i].result, vecs[i].vaddr, vecs[i].rf_we, vecs[i].waddr, vecs[i].op,
               vecs[i].num, vecs[i].wdata, vecs[i].mask, vecs[i].rvalue, vecs[i].ertn, vecs[i].ex);
         @(negedge clk);
         check($sformatf("v%0d wb_ex", i),       {31'b0, wb_ex},         {31'b0, vecs[i].e_ex});
         check($sformatf("v%0d ecode", i),       {26'b0, wb_ecode},      {26'b0, vecs[i].e_ecode});
         check($sformatf("v%0d esubcode", i),    {23'b0, wb_esubcode},   32'h0);
         check($sformatf("v%0d wb_pc", i),       wb_pc,                  vecs[i].pc);
         check($sformatf("v%0d wb_vaddr", i),    wb_vaddr,               vecs[i].vaddr);
         check($sformatf("v%0d ertn_flush", i),  {31'b0, ertn_flush},    {31'b0, vecs[i].e_ertn});
         check($sformatf("v%0d wb_flush", i),    {31'b0, wb_flush},      {31'b0, vecs[i].e_ex | vecs[i].e_ertn});
         check($sformatf("v%0d rf_we", i),       {31'b0, rf_we},         {31'b0, vecs[i].e_rf_we});
         check($sformatf("v%0d rf_waddr", i),    {27'b0, rf_waddr},      {27'b0, vecs[i].waddr});
         check($sformatf("v%0d rf_wdata", i),    rf_wdata,               vecs[i].e_rf_wdata);
         check($sformatf("v%0d csr_re", i),      {31'b0, csr_re},        {31'b0, vecs[i].e_re});
         check($sformatf("v%0d csr_we", i),      {31'b0, csr_we},        {31'b0, vecs[i].e_we});
         check($sformatf("v%0d csr_num", i),     {18'b0, csr_num},       {18'b0, vecs[i].num});
         check($sformatf("v%0d csr_wmask", i),   csr_wmask,              vecs[i].e_wmask);
         check($sformatf("v%0d csr_wvalue", i),  csr_wvalue,             vecs[i].wdata);
         if (vecs[i].e_ex) exp_ex++;
         else exp_retire++;
         ms_to_ws_valid = 1'b0;
         @(negedge clk);
      end
      check("table retire", perf_retire_cnt, exp_retire);
      check("table ex_cnt", {16'b0, perf_ex_cnt}, exp_ex);

      // Five back-to-back clean instructions from reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_clean(32'h1c003000 + 32'(k * 4), 32'h00000100 + 32'(k));
         @(negedge clk);
         check($sformatf("b2b%0d rf_we", k), {31'b0, rf_we}, 32'h1);
         check($sformatf("b2b%0d rf_wdata", k), rf_wdata, 32'h00000100 + 32'(k));
      end
      ms_to_ws_valid = 1'b0;
      @(negedge clk);
      check("b2b retire", perf_retire_cnt, 32'd5);
      check("b2b ex_cnt", {16'b0, perf_ex_cnt}, 32'd0);

      // Exception counter saturation
      force dut.perf_ex_cnt = 16'hFFFE;
      #1;
      release dut.perf_ex_cnt;
      drive(32'h1c004000, 32'h0, 32'h0, 1'b0, 5'd0, 2'b00, 14'h0, 32'h0, 32'h0, 32'h0, 1'b0, 6'b000010);
      @(negedge clk);
      ms_to_ws_valid = 1'b0;
      @(negedge clk);
      check("sat step", {16'b0, perf_ex_cnt}, 32'h0000FFFF);
      drive(32'h1c004004, 32'h0, 32'h0, 1'b0, 5'd0, 2'b00, 14'h0, 32'h0, 32'h0, 32'h0, 1'b0, 6'b000100);
      @(negedge clk);
      ms_to_ws_valid = 1'b0;
      @(negedge clk);
      check("sat hold", {16'b0, perf_ex_cnt}, 32'h0000FFFF);
      check("sat retire", perf_retire_cnt, 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
